// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-add unsigned multiplier with a result-register write sequencer.
// The operands are captured on start. WIDTH iterations follow, then LO and HI register writes, then a done pulse.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic                 regWrite,
    output logic [1:0]           decOut,
    output logic [WIDTH-1:0]     writeData,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ITER,
        S_WRLO,
        S_WRHI,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH:0]       sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        // A is below 2^WIDTH after every shift, so this WIDTH+1-bit sum never overflows.
        sum       = q_q[0] ? (a_q + {1'b0, m_q}) : a_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                a_d   = {1'b0, sum[WIDTH:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Capture the post-shift {A[WIDTH-1:0],Q} of this final iteration.
                    product_d = {sum, q_q[WIDTH-1:1]};
                    state_d   = S_WRLO;
                end
            end
            S_WRLO:  state_d = S_WRHI;
            S_WRHI:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend only on state and registered data.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        regWrite  = 1'b0;
        decOut    = 2'b00;
        writeData = '0;
        case (state_q)
            S_WRLO: begin
                regWrite  = 1'b1;
                decOut    = 2'b01;
                writeData = product_q[WIDTH-1:0];
            end
            S_WRHI: begin
                regWrite  = 1'b1;
                decOut    = 2'b10;
                writeData = product_q[2*WIDTH-1:WIDTH];
            end
            default: ;
        endcase
    end

    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: directed and random multiplies against a plain-arithmetic model.
module tb_shift_add_mult_ctrl;
  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic        regWrite;
  logic [1:0]  decOut;
  logic [15:0] writeData;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  // Observations gathered by run_mult, relative to the accepting edge k.
  // An observation after edge k+n belongs to the cycle ending at edge k+n+1.
  logic [15:0] obs_lo, obs_hi;
  logic [31:0] obs_prod, obs_prod_late;
  int obs_lo_cyc, obs_hi_cyc, obs_done_cyc, obs_done_cnt, obs_wr_cnt, obs_dec_bad, obs_busy_bad;

  shift_add_mult_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .regWrite(regWrite), .decOut(decOut),
    .writeData(writeData), .product(product)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model_mult(input logic [15:0] m, input logic [15:0] q);
    return 32'(m) * 32'(q);
  endfunction

  // Drive one multiply and record the write sequence. A nonzero perturb re-pulses start with new operands then.
  task automatic run_mult(input logic [15:0] m, input logic [15:0] q, input int perturb);
    obs_lo = 'x; obs_hi = 'x; obs_prod = 'x; obs_prod_late = 'x;
    obs_lo_cyc = -1; obs_hi_cyc = -1; obs_done_cyc = -1;
    obs_done_cnt = 0; obs_wr_cnt = 0; obs_dec_bad = 0; obs_busy_bad = 0;
    @(negedge clk);
    start = 1'b1; multiplicand = m; multiplier = q;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk);
      #1;
      if (busy !== (c <= 18)) obs_busy_bad++;
      if (decOut === 2'b11) obs_dec_bad++;
      if (!regWrite && (decOut !== 2'b00 || writeData !== 16'h0)) obs_dec_bad++;
      if (regWrite === 1'b1) begin
        obs_wr_cnt++;
        if (decOut === 2'b01) begin obs_lo = writeData; obs_lo_cyc = c; end
        if (decOut === 2'b10) begin obs_hi = writeData; obs_hi_cyc = c; end
      end
      if (done === 1'b1) begin
        obs_done_cnt++; obs_done_cyc = c; obs_prod = product;
        if (regWrite !== 1'b0) obs_dec_bad++;
      end
      if (c == 22) obs_prod_late = product;
      if (perturb != 0 && c == perturb) begin
        start = 1'b1;
        multiplicand = 16'($urandom);
        multiplier = 16'($urandom);
      end
      if (perturb != 0 && c == perturb + 1) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    #2 reset = 1'b1;
    #1;
    checks++; if ({busy, done, regWrite, decOut} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, regWrite, decOut}); end
    checks++; if (writeData !== 16'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0000", writeData); end
    checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product got=%h exp=00000000", product); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic;
    run_mult(16'h0003, 16'h0005, 0);
    checks++; if (obs_lo_cyc !== 16 || obs_lo !== 16'h000F) begin errors++; $display("FAIL basic_lo cyc=%0d data=%h exp cyc=16 data=000F", obs_lo_cyc, obs_lo); end
    checks++; if (obs_hi_cyc !== 17 || obs_hi !== 16'h0000) begin errors++; $display("FAIL basic_hi cyc=%0d data=%h exp cyc=17 data=0000", obs_hi_cyc, obs_hi); end
    checks++; if (obs_done_cyc !== 18 || obs_done_cnt !== 1) begin errors++; $display("FAIL basic_done cyc=%0d cnt=%0d exp cyc=18 cnt=1", obs_done_cyc, obs_done_cnt); end
    checks++; if (obs_prod !== 32'h0000000F) begin errors++; $display("FAIL basic_product got=%h exp=0000000F", obs_prod); end
    checks++; if (obs_busy_bad !== 0 || obs_dec_bad !== 0 || obs_wr_cnt !== 2) begin errors++; $display("FAIL basic_ctrl busy_bad=%0d dec_bad=%0d writes=%0d exp 0 0 2", obs_busy_bad, obs_dec_bad, obs_wr_cnt); end
  endtask

  task automatic test_max;
    run_mult(16'hFFFF, 16'hFFFF, 0);
    checks++; if (obs_lo !== 16'h0001 || obs_hi !== 16'hFFFE) begin errors++; $display("FAIL max_writes lo=%h hi=%h exp lo=0001 hi=FFFE", obs_lo, obs_hi); end
    checks++; if (obs_prod !== 32'hFFFE0001 || obs_prod_late !== 32'hFFFE0001) begin errors++; $display("FAIL max_product got=%h late=%h exp=FFFE0001", obs_prod, obs_prod_late); end
  endtask

  task automatic test_zero;
    run_mult(16'h1234, 16'h0000, 0);
    checks++; if (obs_lo !== 16'h0 || obs_hi !== 16'h0 || obs_wr_cnt !== 2) begin errors++; $display("FAIL zero_writes lo=%h hi=%h writes=%0d exp 0000 0000 2", obs_lo, obs_hi, obs_wr_cnt); end
    checks++; if (obs_done_cyc !== 18 || obs_prod !== 32'h0) begin errors++; $display("FAIL zero_done cyc=%0d prod=%h exp cyc=18 prod=00000000", obs_done_cyc, obs_prod); end
    run_mult(16'h0000, 16'hBEEF, 0);
    checks++; if (obs_prod !== 32'h0) begin errors++; $display("FAIL zero_m_product got=%h exp=00000000", obs_prod); end
  endtask

  task automatic test_random;
    logic [15:0] m, q;
    logic [31:0] exp;
    for (int i = 0; i < 10; i++) begin
      m = 16'($urandom); q = 16'($urandom);
      if (i == 0) m = 16'hFFFF;
      if (i == 1) q = 16'h8000;
      exp = model_mult(m, q);
      run_mult(m, q, 0);
      checks++; if (obs_prod !== exp || obs_prod_late !== exp) begin errors++; $display("FAIL rand_product m=%h q=%h got=%h late=%h exp=%h", m, q, obs_prod, obs_prod_late, exp); end
      checks++; if (obs_lo !== exp[15:0] || obs_hi !== exp[31:16]) begin errors++; $display("FAIL rand_writes m=%h q=%h lo=%h hi=%h exp=%h", m, q, obs_lo, obs_hi, exp); end
      checks++; if (obs_dec_bad !== 0 || obs_busy_bad !== 0 || obs_done_cnt !== 1) begin errors++; $display("FAIL rand_ctrl dec_bad=%0d busy_bad=%0d dones=%0d exp 0 0 1", obs_dec_bad, obs_busy_bad, obs_done_cnt); end
    end
  endtask

  task automatic test_ignore;
    run_mult(16'h0007, 16'h0009, 5);
    checks++; if (obs_prod !== 32'h0000003F) begin errors++; $display("FAIL ignore_product got=%h exp=0000003F", obs_prod); end
    checks++; if (obs_done_cnt !== 1 || obs_wr_cnt !== 2 || obs_done_cyc !== 18) begin errors++; $display("FAIL ignore_done cnt=%0d writes=%0d cyc=%0d exp 1 2 18", obs_done_cnt, obs_wr_cnt, obs_done_cyc); end
  endtask

  task automatic test_abort;
    logic [15:0] m, q;
    int wr, dn;
    @(negedge clk);
    start = 1'b1; multiplicand = 16'h1111; multiplier = 16'h2222;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({busy, done, regWrite, decOut} !== 5'b0 || writeData !== 16'h0 || product !== 32'h0) begin errors++; $display("FAIL abort_async ctrl=%b wdata=%h prod=%h exp all zero", {busy, done, regWrite, decOut}, writeData, product); end
    wr = 0; dn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(posedge clk);
      #1;
      if (regWrite === 1'b1) wr++;
      if (done === 1'b1) dn++;
    end
    checks++; if (wr !== 0 || dn !== 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet writes=%0d dones=%0d busy=%b exp 0 0 0", wr, dn, busy); end
    m = 16'($urandom); q = 16'($urandom);
    run_mult(m, q, 0);
    checks++; if (obs_prod !== model_mult(m, q) || obs_done_cyc !== 18) begin errors++; $display("FAIL abort_restart got=%h cyc=%0d exp=%h cyc=18", obs_prod, obs_done_cyc, model_mult(m, q)); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, nd;
    logic [31:0] p1, p2;
    logic [15:0] lo1, lo2;
    d1 = -1; d2 = -1; nd = 0; p1 = 'x; p2 = 'x; lo1 = 'x; lo2 = 'x;
    @(negedge clk);
    start = 1'b1; multiplicand = 16'd2; multiplier = 16'd3;
    @(posedge clk);
    #1 multiplicand = 16'd100; multiplier = 16'd100;
    for (int c = 1; c <= 42; c++) begin
      @(posedge clk);
      #1;
      if (c == 20) start = 1'b0;
      if (c == 16 && regWrite === 1'b1) lo1 = writeData;
      if (c == 36 && regWrite === 1'b1) lo2 = writeData;
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) begin d1 = c; p1 = product; end
        if (nd == 2) begin d2 = c; p2 = product; end
      end
    end
    checks++; if (nd !== 2 || d1 !== 18 || d2 !== 38) begin errors++; $display("FAIL b2b_done cnt=%0d at %0d,%0d exp 2 at 18,38", nd, d1, d2); end
    checks++; if (p1 !== 32'h00000006 || p2 !== 32'h00002710) begin errors++; $display("FAIL b2b_product got=%h,%h exp=00000006,00002710", p1, p2); end
    checks++; if (lo1 !== 16'h0006 || lo2 !== 16'h2710) begin errors++; $display("FAIL b2b_lo got=%h,%h exp=0006,2710", lo1, lo2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_random();
    test_ignore();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_add_mult_ctrl.md
SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand width. Only 16 is verified.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a multiply; sampled only in IDLE.
REQ-005 Port: multiplicand  input  WIDTH  operand M; captured on the accepting edge.
REQ-006 Port: multiplier  input  WIDTH  operand Q; captured on the accepting edge.
REQ-007 Port: busy  output  1  high whenever state is not IDLE.
REQ-008 Port: done  output  1  one-cycle completion pulse.
REQ-009 Port: regWrite  output  1  write strobe to the result register pair.
REQ-010 Port: decOut  output  2  one-hot register select: bit0 = LO register, bit1 = HI register.
REQ-011 Port: writeData  output  WIDTH  data for the selected register.
REQ-012 Port: product  output  2*WIDTH  final product; held stable from DONE until the next accepted start.

Function
REQ-013 The FSM shall have five states: IDLE, ITER, WRLO, WRHI, DONE.
REQ-014 IDLE with start=1 at edge k shall do all of the following:
- capture M and Q;
- clear accumulator A (WIDTH+1 bits, including carry);
- clear iteration counter;
- go to ITER.
REQ-015 IDLE with start=0 shall remain in IDLE with no register changes.
REQ-016 Each ITER cycle shall do the following:
- if Q[0]=1, set A = A + M (WIDTH+1-bit sum, carry kept in A's MSB);
- then shift {A,Q} right by one, with a zero entering the MSB;
- increment the counter.
REQ-017 The arithmetic is unsigned; {A[WIDTH-1:0],Q} after WIDTH iterations shall equal multiplicand*multiplier exactly, with no overflow.
REQ-018 ITER shall last exactly WIDTH cycles (edges k+1..k+WIDTH), then go to WRLO.
REQ-019 The counter shall be wide enough to hold WIDTH with no wrap; the terminal test is count==WIDTH-1 in the last ITER cycle.
REQ-020 On entry to WRLO, product shall be loaded with {A[WIDTH-1:0],Q}.
REQ-021 In WRLO (one cycle), outputs shall be regWrite=1, decOut=01, writeData=product[WIDTH-1:0]; next state WRHI.
REQ-022 In WRHI (one cycle), outputs shall be regWrite=1, decOut=10, writeData=product[2*WIDTH-1:WIDTH]; next state DONE.
REQ-023 In DONE (one cycle), outputs shall be done=1 and regWrite=0; next state IDLE.
REQ-024 With WIDTH=16, start accepted at edge k gives:
- WRLO during cycle k+17;
- WRHI during cycle k+18;
- done high during cycle k+19;
- IDLE again at k+20.
REQ-025 Outside WRLO and WRHI, regWrite shall be 0, decOut shall be 00 and writeData shall be 0.
REQ-026 decOut shall never have more than one bit set.
REQ-027 All outputs shall be registered or decoded from state only; there shall be no combinational path from start or the operands to any output.
REQ-028 start asserted while busy shall be ignored; operand changes while busy shall not affect the result.
REQ-029 start held high continuously shall be accepted again in the first IDLE cycle after DONE, giving back-to-back operations 20 cycles apart.
REQ-030 Boundary cases: a zero operand shall give product 0. FFFF*FFFF shall give FFFE0001; the carry into A's MSB shall be preserved.

Reset
REQ-031 reset=1 shall immediately, with no clock required, force the following:
- state=IDLE;
- busy=0, done=0, regWrite=0, decOut=00;
- writeData=0, product=0;
- A, Q, M and the counter = 0.
REQ-032 reset asserted mid-operation (any non-IDLE state) shall abort with no further register writes; no done pulse shall follow.
REQ-033 After reset deasserts, the first rising edge with start=1 shall be accepted normally.

Verification
REQ-034 The bench shall cover these directed scenarios:
- Basic: M=0003, Q=0005, start pulse at edge k -> regWrite+decOut=01 with writeData=000F at k+17; decOut=10 with writeData=0000 at k+18; done at k+19; product=0000000F.
- Max: M=FFFF, Q=FFFF -> LO write FFFE... correction: LO write 0001, HI write FFFE; product=FFFE0001.
- Zero: M=1234, Q=0000 -> both writes 0000; done at k+19.
- Ignore: start re-pulsed and operands changed at k+5 -> result unchanged (7*9=0000003F); exactly one done pulse.
- Abort: reset asserted at k+8 -> outputs zero asynchronously; no regWrite or done; new start after release yields correct product.
- Back-to-back: start held high, operand pairs (2,3) then (100,100) -> done pulses 20 cycles apart; products 00000006 and 00002710.
